cd_rx_ram_ring: RTL and testbench
=================================

Name: cd_rx_ram_ring

Overview:
- Parametrised successor to the double-buffered RX frame RAM.
- Holds up to PAGES-1 committed received frames in a ring of PAGE_BYTES pages, plus one page that is always being written.
- Sits between cd_rx_bytes (write side) and cd_csr (read side).
- Adds a per-page frame length, a per-page error flag, an occupancy count, and a flush-all command with defined collision rules.

Parameters:
PAGES, 4, number of pages; power of two, >=2; at most PAGES-1 committed frames
PAGE_BYTES, 256, bytes per page; power of two, <=256
AW, log2(PAGE_BYTES), byte address width within a page
CW, log2(PAGES)+1, occupancy count width

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
wr_byte  in  8  write data
wr_addr  in  AW  byte offset in the current write page
wr_en  in  1  write strobe
wr_err  in  1  marks the current frame as errored (sticky until switch)
switch  in  1  commit the current write page as a frame
switch_fail  out  1  1-cycle pulse: commit refused, ring full
rd_addr  in  AW  byte offset in the oldest committed page
rd_en  in  1  read enable (power gating)
rd_byte  out  8  registered read data
rd_frm_len  out  AW+1  length of the oldest frame (highest written addr + 1)
rd_err  out  1  error flag of the oldest frame
rd_done  in  1  release the oldest frame
rd_done_all  in  1  flush all committed frames
unread  out  1  count != 0
pending_cnt  out  CW  number of committed frames

Behaviour:
- Async reset:
  - wr_page, rd_page, count, wr_len and wr_err_q are 0.
  - rd_byte, switch_fail and all per-page len/err registers are 0.
  - RAM contents are not reset.
- Write path: wr_en writes wr_byte to RAM[{wr_page, wr_addr}] on the same edge.
  - wr_len <= max(wr_len, wr_addr+1).
  - wr_err_q |= wr_err, evaluated every cycle.
- Read path: on rd_en, rd_byte <= RAM[{rd_page, rd_addr}] next cycle (1-cycle latency).
  - Without rd_en, rd_byte holds its value.
  - rd_addr is not range-checked against rd_frm_len.
- Combinational outputs: rd_frm_len = len[rd_page], rd_err = err[rd_page], unread = (count != 0), pending_cnt = count.
  - Values are undefined-but-stable when count == 0.
- Per-edge priority order: rd_done_all, then rd_done, then switch.
- rd_done_all: rd_page <= wr_page, count <= 0; rd_done is ignored that cycle.
- rd_done with count == 0: ignored.
- rd_done with count > 0: rd_page <= rd_page+1 (mod PAGES), count decrements.
- switch is accepted when count_after_release < PAGES-1, where count_after_release is count after rd_done/rd_done_all in the same cycle.
  - On accept: len[wr_page] <= wr_len, err[wr_page] <= wr_err_q | wr_err, wr_page <= wr_page+1, count increments.
  - With a same-cycle rd_done_all, the new frame survives and count becomes 1.
- switch refused: switch_fail = 1 for the next cycle; wr_page does not advance and the frame is discarded.
- After any switch (accepted or refused): wr_len <= 0, wr_err_q <= 0.
- wr_en in the same cycle as switch: the byte goes to the old page and counts toward its length.
- Invariants:
  - wr_page == rd_page + count (mod PAGES).
  - count never exceeds PAGES-1.
  - Pointers wrap modulo PAGES.

Decomposition:
- Package cd_pkg: CD_PAGE_BYTES_DEF = 256 and a clog2 helper function.
- Sub-module cd_sdp_ram(DEPTH = PAGES*PAGE_BYTES, DW = 8):
  - One synchronous write port.
  - One registered read port with read enable.
  - Inferred block RAM.
- Ring control logic stays in cd_rx_ram_ring.

Test Plan:
1. Reset, then write 5 bytes at addrs 0..4 and switch → pending_cnt = 1, unread = 1, rd_frm_len = 5, rd_err = 0; read addr 3 with rd_en → rd_byte equals the 4th written byte one cycle later.
2. PAGES=4: commit 3 frames, then a 4th switch → switch_fail pulses exactly 1 cycle, pending_cnt stays 3; the next frame is written into the same page and old frames are intact.
3. Count 3 with rd_done and switch in the same cycle → switch accepted, switch_fail = 0, pending_cnt stays 3, oldest frame is now the former second frame.
4. Pulse wr_err mid-frame, write addrs 0..9, switch → rd_err = 1, rd_frm_len = 10; the following clean frame reads rd_err = 0 after rd_done.
5. Commit 2 frames, then rd_done_all together with switch → pending_cnt = 1, and the oldest frame is the one just committed.
6. Assert reset mid-frame with count = 2 → all outputs are 0 immediately (async); the next frame commits into page 0 with the correct length.

Source files
------------

// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared constants and helpers for the cd_* receive path
package cd_pkg;

  localparam int CD_PAGE_BYTES_DEF = 256;

  function automatic int cd_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/cd_rx_ram_ring_if.sv
// rtl/cd_rx_ram_ring_if.sv - write/read bus between cd_rx_bytes, the frame ring and cd_csr
interface cd_rx_ram_ring_if
  import cd_pkg::*;
#(
  parameter int AW = cd_clog2(CD_PAGE_BYTES_DEF),
  parameter int CW = 3
);
  logic [7:0]    wr_byte;
  logic [AW-1:0] wr_addr;
  logic          wr_en;
  logic          wr_err;
  logic          switch;
  logic          switch_fail;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [7:0]    rd_byte;
  logic [AW:0]   rd_frm_len;
  logic          rd_err;
  logic          rd_done;
  logic          rd_done_all;
  logic          unread;
  logic [CW-1:0] pending_cnt;

  modport master (
    output wr_byte, wr_addr, wr_en, wr_err, switch, rd_addr, rd_en, rd_done, rd_done_all,
    input  switch_fail, rd_byte, rd_frm_len, rd_err, unread, pending_cnt
  );

  modport slave (
    input  wr_byte, wr_addr, wr_en, wr_err, switch, rd_addr, rd_en, rd_done, rd_done_all,
    output switch_fail, rd_byte, rd_frm_len, rd_err, unread, pending_cnt
  );
endinterface

// File: rtl/cd_sdp_ram.sv
// rtl/cd_sdp_ram.sv - simple dual-port RAM, sync write, registered read with enable
module cd_sdp_ram
  import cd_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int DW = 8,
  localparam int ABITS = cd_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ABITS-1:0] waddr,
  input  logic [DW-1:0]    wdata,
  input  logic             re,
  input  logic [ABITS-1:0] raddr,
  output logic [DW-1:0]    rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the output register is reset; array contents survive reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cd_rx_ram_ring.sv
// rtl/cd_rx_ram_ring.sv - ring of frame pages: one page being filled, up to PAGES-1 committed
module cd_rx_ram_ring
  import cd_pkg::*;
#(
  parameter int PAGES = 4,
  parameter int PAGE_BYTES = CD_PAGE_BYTES_DEF
) (
  input logic             clk,
  input logic             reset,
  cd_rx_ram_ring_if.slave bus
);

  localparam int AW = cd_clog2(PAGE_BYTES);
  localparam int PW = cd_clog2(PAGES);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_page, rd_page, rd_page_nxt;
  logic [CW-1:0] count, rel_cnt;
  logic [AW:0]   wr_len, len_in;
  logic          wr_err_q, err_in;
  logic          accept;
  logic          switch_fail_q;
  logic [AW:0]   len_q [PAGES];
  logic [PAGES-1:0] err_q;

  // Releases are resolved first so a commit can reuse the slot freed this cycle.
  always_comb begin
    rel_cnt     = count;
    rd_page_nxt = rd_page;
    if (bus.rd_done_all) begin
      rel_cnt     = '0;
      rd_page_nxt = wr_page;
    end else if (bus.rd_done && count != '0) begin
      rel_cnt     = count - CW'(1);
      rd_page_nxt = rd_page + PW'(1);
    end
    accept = bus.switch && (rel_cnt < CW'(PAGES - 1));
    len_in = wr_len;
    if (bus.wr_en && ({1'b0, bus.wr_addr} + (AW+1)'(1)) > wr_len)
      len_in = {1'b0, bus.wr_addr} + (AW+1)'(1);
    err_in = wr_err_q | bus.wr_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_page       <= '0;
      rd_page       <= '0;
      count         <= '0;
      wr_len        <= '0;
      wr_err_q      <= 1'b0;
      switch_fail_q <= 1'b0;
      err_q         <= '0;
      for (int i = 0; i < PAGES; i++) len_q[i] <= '0;
    end else begin
      switch_fail_q <= bus.switch && !accept;
      rd_page       <= rd_page_nxt;
      count         <= rel_cnt + CW'(accept);
      if (accept) begin
        len_q[wr_page] <= len_in;
        err_q[wr_page] <= err_in;
        wr_page        <= wr_page + PW'(1);
      end
      // A refused commit drops the frame, so the page restarts empty either way.
      if (bus.switch) begin
        wr_len   <= '0;
        wr_err_q <= 1'b0;
      end else begin
        wr_len   <= len_in;
        wr_err_q <= err_in;
      end
    end
  end

  cd_sdp_ram #(
    .DEPTH(PAGES * PAGE_BYTES),
    .DW   (8)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (bus.wr_en),
    .waddr({wr_page, bus.wr_addr}),
    .wdata(bus.wr_byte),
    .re   (bus.rd_en),
    .raddr({rd_page, bus.rd_addr}),
    .rdata(bus.rd_byte)
  );

  assign bus.switch_fail = switch_fail_q;
  assign bus.rd_frm_len  = len_q[rd_page];
  assign bus.rd_err      = err_q[rd_page];
  assign bus.unread      = (count != '0);
  assign bus.pending_cnt = count;

endmodule

// File: tb/tb_cd_rx_ram_ring.sv
// tb/tb_cd_rx_ram_ring.sv - scoreboard bench for the frame ring
module tb_cd_rx_ram_ring;

    localparam int PAGES = 4;
    localparam int PAGE_BYTES = 256;
    localparam int AW = 8;
    localparam int CW = 3;

    localparam int S_CNT  = 0;
    localparam int S_UNR  = 1;
    localparam int S_LEN  = 2;
    localparam int S_ERR  = 3;
    localparam int S_BYTE = 4;
    localparam int S_FAIL = 5;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    cd_rx_ram_ring_if #(.AW(AW), .CW(CW)) bus ();

    cd_rx_ram_ring #(.PAGES(PAGES), .PAGE_BYTES(PAGE_BYTES)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];

    task automatic expect_at(input int dly, input int sel, input int val, input string name);
        exp_t e;
        e.cyc  = cyc + dly;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic now_chk(input int act, input int exp_v, input string name);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic int sample(input int sel);
        case (sel)
            S_CNT:   return int'(bus.pending_cnt);
            S_UNR:   return int'(bus.unread);
            S_LEN:   return int'(bus.rd_frm_len);
            S_ERR:   return int'(bus.rd_err);
            S_BYTE:  return int'(bus.rd_byte);
            default: return int'(bus.switch_fail);
        endcase
    endfunction

    always @(negedge clk) begin
        int i;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                int act;
                act = sample(sb[i].sel);
                n_chk++;
                if (act != sb[i].val) begin
                    n_fail++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", sb[i].name, act, sb[i].val, cyc);
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    function automatic logic [7:0] dat(input int id, input int a);
        return 8'((id % 16) * 16 + (a % 16));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_frame(input int id, input int n, input int err_at);
        for (int a = 0; a < n; a++) begin
            bus.wr_byte = dat(id, a);
            bus.wr_addr = AW'(a);
            bus.wr_en   = 1'b1;
            bus.wr_err  = (a == err_at);
            step();
        end
        bus.wr_en  = 1'b0;
        bus.wr_err = 1'b0;
    endtask

    task automatic commit();
        bus.switch = 1'b1;
        step();
        bus.switch = 1'b0;
    endtask

    task automatic release_one();
        bus.rd_done = 1'b1;
        step();
        bus.rd_done = 1'b0;
    endtask

    task automatic rd_chk(input int addr, input logic [7:0] v, input string name);
        bus.rd_addr = AW'(addr);
        bus.rd_en   = 1'b1;
        expect_at(1, S_BYTE, int'(v), name);
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic chk_cnt(input int cnt, input string name);
        expect_at(0, S_CNT, cnt, {name, "_cnt"});
        expect_at(0, S_UNR, (cnt != 0) ? 1 : 0, {name, "_unread"});
    endtask

    task automatic chk_head(input int cnt, input int len, input int err, input string name);
        chk_cnt(cnt, name);
        expect_at(0, S_LEN, len, {name, "_len"});
        expect_at(0, S_ERR, err, {name, "_err"});
    endtask

    initial begin
        bus.wr_byte = '0; bus.wr_addr = '0; bus.wr_en = 1'b0; bus.wr_err = 1'b0;
        bus.switch = 1'b0; bus.rd_addr = '0; bus.rd_en = 1'b0;
        bus.rd_done = 1'b0; bus.rd_done_all = 1'b0;

        step();
        chk_head(0, 0, 0, "rst");
        expect_at(0, S_BYTE, 0, "rst_byte");
        expect_at(0, S_FAIL, 0, "rst_fail");
        step();
        reset = 1'b0;
        step();

        wr_frame(1, 5, -1);
        commit();
        chk_head(1, 5, 0, "t1");
        now_chk(int'(bus.pending_cnt), 1, "t1_now_cnt");
        now_chk(int'(bus.rd_frm_len), 5, "t1_now_len");
        rd_chk(3, dat(1, 3), "t1_rd");

        wr_frame(2, 6, -1);
        commit();
        wr_frame(3, 7, -1);
        commit();
        chk_head(3, 5, 0, "t2_full");
        wr_frame(4, 4, -1);
        bus.switch = 1'b1;
        expect_at(1, S_FAIL, 1, "t2_fail_pulse");
        expect_at(2, S_FAIL, 0, "t2_fail_clear");
        expect_at(1, S_CNT, 3, "t2_cnt_hold");
        step();
        bus.switch = 1'b0;
        step();
        chk_head(3, 5, 0, "t2_old");
        rd_chk(0, dat(1, 0), "t2_old_rd");
        release_one();
        chk_head(2, 6, 0, "t2_rel");
        wr_frame(5, 3, -1);
        commit();
        chk_head(3, 6, 0, "t2_refill");

        wr_frame(6, 2, -1);
        bus.rd_done = 1'b1;
        bus.switch  = 1'b1;
        expect_at(1, S_FAIL, 0, "t3_no_fail");
        step();
        bus.rd_done = 1'b0;
        bus.switch  = 1'b0;
        n_chk++;
        if (bus.switch_fail !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_now_fail: got %0b expected 0 (cycle %0d)", bus.switch_fail, cyc);
        end
        chk_head(3, 7, 0, "t3");
        rd_chk(2, dat(3, 2), "t3_rd");
        release_one();
        chk_head(2, 3, 0, "t3_f5");
        rd_chk(1, dat(5, 1), "t3_f5_rd");
        release_one();
        chk_head(1, 2, 0, "t3_f6");
        release_one();
        chk_cnt(0, "t3_empty");
        release_one();
        chk_cnt(0, "t3_empty_rel");

        wr_frame(7, 10, 4);
        commit();
        chk_head(1, 10, 1, "t4_err");
        wr_frame(8, 1, -1);
        bus.wr_byte = dat(8, 1);
        bus.wr_addr = AW'(1);
        bus.wr_en   = 1'b1;
        bus.switch  = 1'b1;
        step();
        bus.wr_en  = 1'b0;
        bus.switch = 1'b0;
        chk_cnt(2, "t4_two");
        release_one();
        chk_head(1, 2, 0, "t4_clean");
        rd_chk(1, dat(8, 1), "t4_rd");
        release_one();
        chk_cnt(0, "t4_empty");

        wr_frame(9, 4, -1);
        commit();
        wr_frame(10, 5, -1);
        commit();
        chk_cnt(2, "t5_two");
        wr_frame(11, 3, -1);
        bus.rd_done_all = 1'b1;
        bus.rd_done     = 1'b1;
        bus.switch      = 1'b1;
        step();
        bus.rd_done_all = 1'b0;
        bus.rd_done     = 1'b0;
        bus.switch      = 1'b0;
        chk_head(1, 3, 0, "t5_survivor");
        now_chk(int'(bus.pending_cnt), 1, "t5_now_cnt");
        rd_chk(2, dat(11, 2), "t5_rd");
        bus.rd_done_all = 1'b1;
        step();
        bus.rd_done_all = 1'b0;
        chk_cnt(0, "t5_flush");

        wr_frame(12, 2, -1);
        commit();
        wr_frame(13, 3, -1);
        commit();
        chk_cnt(2, "t6_two");
        wr_frame(14, 8, -1);
        reset = 1'b1;
        chk_head(0, 0, 0, "t6_rst");
        expect_at(0, S_BYTE, 0, "t6_rst_byte");
        expect_at(0, S_FAIL, 0, "t6_rst_fail");
        step();
        now_chk(int'(bus.pending_cnt), 0, "t6_now_cnt");
        now_chk(int'(bus.unread), 0, "t6_now_unread");
        now_chk(int'(bus.rd_byte), 0, "t6_now_byte");
        reset = 1'b0;
        step();
        wr_frame(15, 6, -1);
        commit();
        chk_head(1, 6, 0, "t6_after");
        rd_chk(5, dat(15, 5), "t6_rd");

        repeat (4) step();
        foreach (sb[k]) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: never sampled, expected %0d at cycle %0d", sb[k].name, sb[k].val, sb[k].cyc);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
